// File: rtl/smem_responder_pkg.sv
// Shared definitions for the GPU shared-memory responder: default geometry,
// FSM state encoding and load/store op encoding.
package gpu_smem_pkg;

    localparam int SMEM_ADDR_W  = 12;
    localparam int SMEM_DATA_W  = 8;
    localparam int SMEM_N_CORES = 16;

    typedef enum logic [1:0] {
        SMEM_IDLE   = 2'd0,
        SMEM_ACCESS = 2'd1,
        SMEM_RESP   = 2'd2
    } smem_state_t;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } smem_op_t;

endpackage

// File: rtl/smem_responder_if.sv
// Core-array side of the shared-memory responder: per-core request/address/data
// vectors in, broadcast read data and one-hot completion out.
interface smem_responder_if
    import gpu_smem_pkg::*;
#(
    parameter int N_CORES = SMEM_N_CORES,
    parameter int ADDR_W  = SMEM_ADDR_W,
    parameter int DATA_W  = SMEM_DATA_W
);
    logic [N_CORES-1:0]        mem_req_ld;
    logic [N_CORES-1:0]        mem_req_st;
    logic [N_CORES*ADDR_W-1:0] addr_shared_memory;
    logic [N_CORES*DATA_W-1:0] mem_dat_st;
    logic [DATA_W-1:0]         mem_dat;
    logic [N_CORES-1:0]        val_data;
    logic                      busy;

    modport master (
        output mem_req_ld,
        output mem_req_st,
        output addr_shared_memory,
        output mem_dat_st,
        input  mem_dat,
        input  val_data,
        input  busy
    );

    modport slave (
        input  mem_req_ld,
        input  mem_req_st,
        input  addr_shared_memory,
        input  mem_dat_st,
        output mem_dat,
        output val_data,
        output busy
    );
endinterface

// File: rtl/smem_rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward from
// ptr+1, wrapping modulo N_CORES.
module smem_rr_arbiter
    import gpu_smem_pkg::*;
#(
    parameter int N_CORES = SMEM_N_CORES
) (
    input  logic [N_CORES-1:0]         req,
    input  logic [$clog2(N_CORES)-1:0] ptr,
    output logic [$clog2(N_CORES)-1:0] grant_idx,
    output logic                       grant_vld
);
    localparam int IDX_W = $clog2(N_CORES);

    function automatic int wrap_idx(input logic [IDX_W-1:0] p, input int off);
        return (int'(p) + 1 + off) % N_CORES;
    endfunction

    // rot[0] is the highest-priority candidate (the core just after ptr)
    logic [N_CORES-1:0] rot;

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_rot
        assign rot[gi] = req[wrap_idx(ptr, gi)];
    end

    int sel;

    always_comb begin
        grant_vld = 1'b0;
        sel       = 0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_vld = 1'b1;
                sel       = i;
            end
        end
        grant_idx = IDX_W'(wrap_idx(ptr, sel));
    end

endmodule

// File: rtl/smem_responder.sv
// Shared-memory responder: round-robin among core load/store requests, one
// 3-cycle transaction at a time. Optional SMEM_CONFLICT_CNT_EN adds conflict_cnt.
module smem_responder
    import gpu_smem_pkg::*;
#(
    parameter int N_CORES = SMEM_N_CORES,
    parameter int ADDR_W  = SMEM_ADDR_W,
    parameter int DATA_W  = SMEM_DATA_W
) (
    input  logic        clk,
    input  logic        reset,
`ifdef SMEM_CONFLICT_CNT_EN
    output logic [15:0] conflict_cnt,
`endif
    smem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(N_CORES);
    localparam int DEPTH = 1 << ADDR_W;

    smem_state_t        state_reg;
    smem_op_t           op_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [N_CORES-1:0] val_data_reg;
    logic [DATA_W-1:0]  mem_dat_reg;
    logic               busy_reg;
    logic [DATA_W-1:0]  rd_data_reg;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0]  addr_arr  [N_CORES];
    logic [DATA_W-1:0]  wdata_arr [N_CORES];

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.addr_shared_memory[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = bus.mem_dat_st[gi*DATA_W +: DATA_W];
    end

    logic [N_CORES-1:0] pend;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;

    assign pend = bus.mem_req_ld | bus.mem_req_st;

    smem_rr_arbiter #(.N_CORES(N_CORES)) u_arb (
        .req       (pend),
        .ptr       (rr_ptr_reg),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= SMEM_IDLE;
            op_reg       <= OP_LD;
            grant_reg    <= '0;
            rr_ptr_reg   <= IDX_W'(N_CORES - 1);
            addr_reg     <= '0;
            wdata_reg    <= '0;
            val_data_reg <= '0;
            mem_dat_reg  <= '0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                SMEM_IDLE: begin
                    val_data_reg <= '0;
                    if (grant_vld) begin
                        grant_reg  <= grant_idx;
                        rr_ptr_reg <= grant_idx;
                        // a core with both bits set is served as a store
                        op_reg     <= bus.mem_req_st[grant_idx] ? OP_ST : OP_LD;
                        addr_reg   <= addr_arr[grant_idx];
                        wdata_reg  <= wdata_arr[grant_idx];
                        busy_reg   <= 1'b1;
                        state_reg  <= SMEM_ACCESS;
                    end
                end
                SMEM_ACCESS: begin
                    val_data_reg <= {{(N_CORES-1){1'b0}}, 1'b1} << grant_reg;
                    state_reg    <= SMEM_RESP;
                end
                SMEM_RESP: begin
                    val_data_reg <= '0;
                    if (op_reg == OP_LD) begin
                        mem_dat_reg <= rd_data_reg;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= SMEM_IDLE;
                end
                default: begin
                    val_data_reg <= '0;
                    busy_reg     <= 1'b0;
                    state_reg    <= SMEM_IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; an async reset during ACCESS leaves state IDLE so the write is skipped
    always_ff @(posedge clk) begin
        if (state_reg == SMEM_ACCESS && op_reg == OP_ST) begin
            mem[addr_reg] <= wdata_reg;
        end
        rd_data_reg <= mem[addr_reg];
    end

    // During a load's RESP the fresh RAM output is presented; otherwise the held value
    assign bus.mem_dat  = (state_reg == SMEM_RESP && op_reg == OP_LD) ? rd_data_reg : mem_dat_reg;
    assign bus.val_data = val_data_reg;
    assign bus.busy     = busy_reg;

`ifdef SMEM_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_reg <= '0;
        end else if (state_reg == SMEM_IDLE && (pend & (pend - 1'b1)) != '0
                     && conflict_cnt_reg != 16'hFFFF) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_smem_responder.sv
// Randomized + directed bench for smem_responder against a transaction-level model.
// Define SMEM_CONFLICT_CNT_EN to also exercise the conflict counter.
module tb_smem_responder;
    import gpu_smem_pkg::*;

    localparam int N  = 16;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    smem_responder_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) sif();

`ifdef SMEM_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    smem_responder #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef SMEM_CONFLICT_CNT_EN
        .conflict_cnt (conflict_cnt),
`endif
        .bus          (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory contents, round-robin history and a 3-cycle transaction timeline
    logic [7:0]  model_mem [4096];
    int          phase     = 0;
    int          last_core = N - 1;
    int          pred_core = 0;
    logic        pred_st   = 1'b0;
    logic [11:0] pred_addr = '0;
    logic [7:0]  pred_data = '0;
    logic [7:0]  exp_dat   = '0;
    logic [15:0] exp_cnt   = '0;
    int          cyc       = 0;
    int          grant_log [$];
    int          grant_cyc [$];
    int          served_cnt [N];
    logic [15:0] seen_val  = '0;
    logic [11:0] pool [8] = '{12'h7FF, 12'h010, 12'h000, 12'hFFF, 12'h456, 12'h800, 12'h0AB, 12'h3C3};

    task automatic monitor();
        logic [15:0] pend;
        logic [15:0] exp_val;
        pend = sif.mem_req_ld | sif.mem_req_st;
        cyc++;
        if (reset) begin
            check("rst_busy", 32'(sif.busy), 32'h0);
            check("rst_val_data", 32'(sif.val_data), 32'h0);
            check("rst_mem_dat", 32'(sif.mem_dat), 32'h0);
`ifdef SMEM_CONFLICT_CNT_EN
            check("rst_conflict_cnt", 32'(conflict_cnt), 32'h0);
`endif
            phase     = 0;
            last_core = N - 1;
            exp_dat   = '0;
            exp_cnt   = '0;
            seen_val  = '0;
            return;
        end
        exp_val = '0;
        if (phase == 1) begin
            exp_val = 16'h1 << pred_core;
            if (!pred_st) exp_dat = model_mem[pred_addr];
        end
        check("val_data", 32'(sif.val_data), 32'(exp_val));
        check("busy", 32'(sif.busy), (phase != 0) ? 32'h1 : 32'h0);
        check("mem_dat", 32'(sif.mem_dat), 32'(exp_dat));
`ifdef SMEM_CONFLICT_CNT_EN
        check("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
`endif
        seen_val = sif.val_data;
        for (int k = 0; k < N; k++) begin
            if (sif.val_data[k]) begin
                served_cnt[k]++;
                grant_log.push_back(k);
                grant_cyc.push_back(cyc);
            end
        end
        if (phase == 1 && pred_st) model_mem[pred_addr] = pred_data;
        if (phase > 0) begin
            phase--;
        end else if (pend != 0) begin
            if ($countones(pend) > 1 && exp_cnt != 16'hFFFF) exp_cnt++;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (last_core + i) % N;
                if (pend[c]) begin
                    pred_core = c;
                    break;
                end
            end
            pred_st   = sif.mem_req_st[pred_core];
            pred_addr = sif.addr_shared_memory[pred_core*AW +: AW];
            pred_data = sif.mem_dat_st[pred_core*DW +: DW];
            last_core = pred_core;
            phase     = 2;
        end
    endtask

    // One clock: observe at negedge, then act as the cores just after posedge
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        sif.mem_req_ld = sif.mem_req_ld & ~seen_val;
        sif.mem_req_st = sif.mem_req_st & ~seen_val;
    endtask

    task automatic raise(input int core, input int kind, input logic [11:0] a, input logic [7:0] d);
        sif.addr_shared_memory[core*AW +: AW] = a;
        sif.mem_dat_st[core*DW +: DW]         = d;
        if (kind != 1) sif.mem_req_ld[core] = 1'b1;
        if (kind != 0) sif.mem_req_st[core] = 1'b1;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((sif.mem_req_ld | sif.mem_req_st) != 0 && n < maxc) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(sif.mem_req_ld | sif.mem_req_st), 32'h0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int before9;
        sif.mem_req_ld         = '0;
        sif.mem_req_st         = '0;
        sif.addr_shared_memory = '0;
        sif.mem_dat_st         = '0;
        repeat (3) tick();
        reset = 1'b0;

        // core 3 store then load at 0x123
        raise(3, 1, 12'h123, 8'hA5);
        drain(20);
        raise(3, 0, 12'h123, 8'h00);
        drain(20);
        check("t1_ld_data", 32'(sif.mem_dat), 32'hA5);

        // seed the address pool
        for (int i = 0; i < 8; i++) raise(i, 1, pool[i], 8'($urandom));
        drain(60);

        // all cores load together from a fresh pointer
        pulse_reset();
        grant_log.delete();
        grant_cyc.delete();
        for (int k = 0; k < N; k++) raise(k, 0, pool[k % 8], 8'h00);
        drain(100);
        check("all16_count", 32'(grant_log.size()), 32'd16);
        for (int i = 0; i < grant_log.size() && i < 16; i++)
            check("all16_order", 32'(grant_log[i]), 32'(i));
        for (int i = 1; i < grant_cyc.size() && i < 16; i++)
            check("all16_gap", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);

        // core 5 store and core 6 load, same address
        grant_log.delete();
        raise(5, 1, 12'h7FF, 8'h3C);
        raise(6, 0, 12'h7FF, 8'h00);
        drain(30);
        check("t3_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check("t3_first", 32'(grant_log[0]), 32'd5);
            check("t3_second", 32'(grant_log[1]), 32'd6);
        end
        check("t3_data", 32'(sif.mem_dat), 32'h3C);

        // both ld and st set: treated as a store
        raise(2, 2, 12'h010, 8'h55);
        drain(20);
        raise(7, 0, 12'h010, 8'h00);
        drain(20);
        check("t4_both_store", 32'(sif.mem_dat), 32'h55);

        // reset during ACCESS of core 9's load; core 2 also waiting
        before9 = served_cnt[9];
        grant_log.delete();
        raise(9, 0, 12'h7FF, 8'h00);
        raise(2, 0, 12'h010, 8'h00);
        tick();
        check("t5_in_access", 32'(sif.busy), 32'h1);
        reset = 1'b1;
        #1;
        check("t5_busy_abort", 32'(sif.busy), 32'h0);
        check("t5_val_abort", 32'(sif.val_data), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        drain(30);
        check("t5_reserved", 32'(served_cnt[9] - before9), 32'd1);
        check("t5_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check("t5_first_after_rst", 32'(grant_log[0]), 32'd2);
            check("t5_second_after_rst", 32'(grant_log[1]), 32'd9);
        end

        // store aborted in ACCESS must not reach memory
        raise(4, 1, 12'h123, 8'h77);
        tick();
        check("t5b_in_access", 32'(sif.busy), 32'h1);
        reset = 1'b1;
        #1;
        sif.mem_req_st[4] = 1'b0;
        tick();
        reset = 1'b0;
        raise(3, 0, 12'h123, 8'h00);
        drain(20);
        check("t5b_no_write", 32'(sif.mem_dat), 32'hA5);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            for (int k = 0; k < N; k++) begin
                if (!(sif.mem_req_ld[k] | sif.mem_req_st[k]) && $urandom_range(7) == 0)
                    raise(k, int'($urandom_range(2)), pool[$urandom_range(7)], 8'($urandom));
            end
            tick();
        end
        drain(200);

`ifdef SMEM_CONFLICT_CNT_EN
        pulse_reset();
        raise(1, 0, pool[0], 8'h00);
        raise(4, 0, pool[1], 8'h00);
        tick();
        check("t6_cnt_first", 32'(conflict_cnt), 32'd1);
        drain(30);
        check("t6_cnt_final", 32'(conflict_cnt), 32'd1);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smem_responder.md
Name: smem_responder

Overview:
- Shared-memory responder for all GPU cores. It is the far end of each core's `mem_req_ld`/`mem_req_st`/`addr_shared_memory`/`mem_dat_st`/`mem_dat`/`val_data` interface.
- Arbitrates round-robin among pending core requests and services one load or store at a time from an internal 2^ADDR_W x DATA_W array.
- Returns a one-cycle `val_data` pulse to the served core.
- Sits between the core array and the shared memory storage; the task scheduler is not involved.

Parameters:
- N_CORES, 16: number of requesting cores; core id = bit index.
- ADDR_W, 12: shared-memory address width (depth 4096).
- DATA_W, 8: data word width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req_ld  in  N_CORES  per-core load request (level; held until served).
- mem_req_st  in  N_CORES  per-core store request (level; held until served).
- addr_shared_memory  in  N_CORES*ADDR_W  per-core address, core k at [k*ADDR_W +: ADDR_W].
- mem_dat_st  in  N_CORES*DATA_W  per-core store data, core k at [k*DATA_W +: DATA_W].
- mem_dat  out  DATA_W  read data, broadcast to all cores.
- val_data  out  N_CORES  one-hot completion pulse, per core.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset state: all outputs 0, FSM = IDLE, rr_ptr = N_CORES-1, grant latches cleared. Array contents are not reset.
- Reset asserted mid-transaction aborts it:
  - no val_data is issued;
  - a store not yet in ACCESS is not written.
- FSM IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles.
- IDLE:
  - pend = mem_req_ld | mem_req_st.
  - If pend != 0, grant g = first set bit searching upward from rr_ptr+1, wrapping modulo N_CORES.
  - Latch g, op, addr[g] and wdata[g]; set rr_ptr <= g; go to ACCESS.
  - If pend == 0, stay in IDLE.
- Op select: st if mem_req_st[g] is set, else ld. If a core has both bits set, store wins and the load bit is ignored; this is a protocol error and is not flagged.
- ACCESS:
  - st: array[addr] <= wdata.
  - ld: synchronous read, rdata <= array[addr].
  - Go to RESP.
- RESP:
  - val_data <= one-hot(g) for exactly this cycle.
  - mem_dat = rdata for ld. For st, mem_dat holds its previous value.
  - Go to IDLE.
- Core handshake:
  - A core samples val_data at the RESP->IDLE edge and drops its request on that same edge.
  - Because arbitration happens only in IDLE, the served core's request is already low there. No re-service occurs, and no blocking window is needed.
- mem_dat is registered and stable from RESP until the next load's RESP.
- Fairness: with all cores requesting continuously, every core is served once per N_CORES transactions (3*N_CORES cycles).
- Address/data inputs of non-granted cores are don't-care.
- Requests that change while not granted are re-evaluated in the next IDLE.
- Same-address store then load, issued by different cores, in consecutive transactions: the load returns the new data, with no hazard at 3-cycle spacing.

Optional Feature:
- Macro: SMEM_CONFLICT_CNT_EN.
- When defined:
  - adds output conflict_cnt [15:0];
  - it increments, saturating at 0xFFFF, on every IDLE cycle where more than one bit of pend is set;
  - it is cleared by reset.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package gpu_smem_pkg holds:
  - default widths (SMEM_ADDR_W=12, SMEM_DATA_W=8, SMEM_N_CORES=16);
  - FSM state encoding SMEM_IDLE=0, SMEM_ACCESS=1, SMEM_RESP=2;
  - op encoding OP_LD=0, OP_ST=1.
- One sub-module, smem_rr_arbiter:
  - combinational round-robin priority pick;
  - inputs req[N_CORES], ptr;
  - outputs grant_idx and grant_vld.
- FSM, latches, array and outputs stay in smem_responder.

Test Plan:
- Reset, then single store by core 3 (addr 0x123, data 0xA5), then load by core 3 from 0x123: val_data = 0x0008 three cycles after each request; the load's mem_dat = 0xA5 in RESP.
- All 16 cores raise mem_req_ld together, each holding until its val_data: grants occur in order 0,1,...,15; each val_data is one cycle wide, spaced 3 cycles apart; there is no repeat grant for the same core.
- Core 5 store (0x7FF, 0x3C) and core 6 load (0x7FF) raised together: core 5 is served first; core 6 then reads 0x3C.
- Core 2 with both ld and st high (addr 0x010, data 0x55): treated as a store; a later load returns 0x55.
- Reset pulsed during ACCESS of a load by core 9: no val_data is issued, busy = 0 immediately, and the held request is re-served after reset release starting from core 0.
- SMEM_CONFLICT_CNT_EN defined, cores 1 and 4 requesting simultaneously: conflict_cnt = 1 after the first IDLE, and is unchanged once only one request remains.
